// File: rtl/vram_arbiter.sv
// Two-port Wishbone arbiter in front of a single VRAM slave: video fetch and host.
// A granted master owns the bus for its whole CYC tenure; every handover idles one cycle.
module vram_arbiter #(
  parameter int unsigned ADR_W = 13,
  parameter int unsigned DAT_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  // video fetch port (read-only)
  input  logic [ADR_W-1:0] V_ADR_I,
  input  logic             V_CYC_I,
  input  logic             V_STB_I,
  output logic             V_ACK_O,
  output logic [DAT_W-1:0] V_DAT_O,
  // host port
  input  logic [ADR_W-1:0] H_ADR_I,
  input  logic             H_CYC_I,
  input  logic             H_STB_I,
  input  logic             H_WE_I,
  input  logic [1:0]       H_SEL_I,
  input  logic [DAT_W-1:0] H_DAT_I,
  output logic [DAT_W-1:0] H_DAT_O,
  output logic             H_ACK_O,
  // VRAM master port
  output logic [ADR_W-1:0] M_ADR_O,
  output logic [DAT_W-1:0] M_DAT_O,
  output logic             M_CYC_O,
  output logic             M_STB_O,
  output logic             M_WE_O,
  output logic [1:0]       M_SEL_O,
  input  logic [DAT_W-1:0] M_DAT_I,
  input  logic             M_ACK_I,
  output logic [1:0]       GNT_O
);

  typedef enum logic [1:0] {StIdle, StVideo, StHost} state_e;

  state_e     state_q;
  logic [1:0] gnt_q;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          // video wins a same-cycle tie
          if (V_CYC_I) begin
            state_q <= StVideo;
            gnt_q   <= 2'b01;
          end else if (H_CYC_I) begin
            state_q <= StHost;
            gnt_q   <= 2'b10;
          end
        end
        StVideo: begin
          if (!V_CYC_I) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
          end
        end
        StHost: begin
          if (!H_CYC_I) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign GNT_O   = gnt_q;
  assign V_DAT_O = M_DAT_I;
  assign H_DAT_O = M_DAT_I;

  always_comb begin
    M_ADR_O = '0;
    M_DAT_O = '0;
    M_CYC_O = 1'b0;
    M_STB_O = 1'b0;
    M_WE_O  = 1'b0;
    M_SEL_O = 2'b00;
    V_ACK_O = 1'b0;
    H_ACK_O = 1'b0;
    unique case (state_q)
      StVideo: begin
        M_ADR_O = V_ADR_I;
        M_CYC_O = V_CYC_I;
        M_STB_O = V_STB_I;
        M_SEL_O = 2'b11;
        V_ACK_O = M_ACK_I;
      end
      StHost: begin
        M_ADR_O = H_ADR_I;
        M_DAT_O = H_DAT_I;
        M_CYC_O = H_CYC_I;
        M_STB_O = H_STB_I;
        M_WE_O  = H_WE_I;
        M_SEL_O = H_SEL_I;
        H_ACK_O = M_ACK_I;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: expectations are queued as stimulus is driven and
// compared against DUT outputs on the following falling edge.
module tb_vram_arbiter;

  localparam int ADR_W = 13;
  localparam int DAT_W = 16;

  localparam int SGnt  = 0;
  localparam int SMCyc = 1;
  localparam int SMStb = 2;
  localparam int SMWe  = 3;
  localparam int SMSel = 4;
  localparam int SMAdr = 5;
  localparam int SMDat = 6;
  localparam int SVAck = 7;
  localparam int SHAck = 8;
  localparam int SVDat = 9;
  localparam int SHDat = 10;

  logic             CLK_I = 1'b0;
  logic             RST_I;
  logic [ADR_W-1:0] V_ADR_I;
  logic             V_CYC_I, V_STB_I, V_ACK_O;
  logic [DAT_W-1:0] V_DAT_O;
  logic [ADR_W-1:0] H_ADR_I;
  logic             H_CYC_I, H_STB_I, H_WE_I, H_ACK_O;
  logic [1:0]       H_SEL_I;
  logic [DAT_W-1:0] H_DAT_I, H_DAT_O;
  logic [ADR_W-1:0] M_ADR_O;
  logic [DAT_W-1:0] M_DAT_O, M_DAT_I;
  logic             M_CYC_O, M_STB_O, M_WE_O, M_ACK_I;
  logic [1:0]       M_SEL_O, GNT_O;

  always #5 CLK_I = ~CLK_I;

  vram_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .V_ADR_I(V_ADR_I), .V_CYC_I(V_CYC_I), .V_STB_I(V_STB_I), .V_ACK_O(V_ACK_O),
    .V_DAT_O(V_DAT_O),
    .H_ADR_I(H_ADR_I), .H_CYC_I(H_CYC_I), .H_STB_I(H_STB_I), .H_WE_I(H_WE_I),
    .H_SEL_I(H_SEL_I), .H_DAT_I(H_DAT_I), .H_DAT_O(H_DAT_O), .H_ACK_O(H_ACK_O),
    .M_ADR_O(M_ADR_O), .M_DAT_O(M_DAT_O), .M_CYC_O(M_CYC_O), .M_STB_O(M_STB_O),
    .M_WE_O(M_WE_O), .M_SEL_O(M_SEL_O), .M_DAT_I(M_DAT_I), .M_ACK_I(M_ACK_I),
    .GNT_O(GNT_O)
  );

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SGnt:    return 32'(GNT_O);
      SMCyc:   return 32'(M_CYC_O);
      SMStb:   return 32'(M_STB_O);
      SMWe:    return 32'(M_WE_O);
      SMSel:   return 32'(M_SEL_O);
      SMAdr:   return 32'(M_ADR_O);
      SMDat:   return 32'(M_DAT_O);
      SVAck:   return 32'(V_ACK_O);
      SHAck:   return 32'(H_ACK_O);
      SVDat:   return 32'(V_DAT_O);
      SHDat:   return 32'(H_DAT_O);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the outputs at the falling edge.
  task automatic drain();
    exp_t e;
    @(negedge CLK_I);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic idle_expect(input string tag);
    push({tag, "_gnt"}, SGnt, 0);
    push({tag, "_mcyc"}, SMCyc, 0);
    push({tag, "_mstb"}, SMStb, 0);
    push({tag, "_vack"}, SVAck, 0);
    push({tag, "_hack"}, SHAck, 0);
  endtask

  initial begin
    RST_I = 1'b0;
    V_ADR_I = '0; V_CYC_I = 1'b1; V_STB_I = 1'b1;
    H_ADR_I = '0; H_CYC_I = 1'b1; H_STB_I = 1'b1; H_WE_I = 1'b0;
    H_SEL_I = 2'b00; H_DAT_I = '0;
    M_DAT_I = '0; M_ACK_I = 1'b1;

    // Reset held with both masters requesting and an ACK present
    tick();
    idle_expect("rst");
    drain();

    // Spurious ACK in IDLE is dropped; read data still flows through
    tick();
    RST_I = 1'b1; V_CYC_I = 1'b0; V_STB_I = 1'b0; H_CYC_I = 1'b0; H_STB_I = 1'b0;
    M_ACK_I = 1'b1; M_DAT_I = 16'h1234;
    idle_expect("spur");
    push("spur_vdat", SVDat, 16'h1234);
    push("spur_hdat", SHDat, 16'h1234);
    drain();
    tick();
    idle_expect("spur2");
    drain();

    // Simultaneous requests: video first, host after one dead cycle
    tick();
    M_ACK_I = 1'b0;
    V_CYC_I = 1'b1; V_STB_I = 1'b1; V_ADR_I = 13'h0123;
    H_CYC_I = 1'b1; H_STB_I = 1'b1;
    idle_expect("tie_req");
    drain();
    tick();
    M_ACK_I = 1'b1;
    push("tie_gnt", SGnt, 1);
    push("tie_mcyc", SMCyc, 1);
    push("tie_madr", SMAdr, 13'h0123);
    push("tie_vack", SVAck, 1);
    push("tie_hack", SHAck, 0);
    drain();
    tick();
    V_CYC_I = 1'b0; V_STB_I = 1'b0;
    push("tie_vdrop_gnt", SGnt, 1);
    push("tie_vdrop_mcyc", SMCyc, 0);
    push("tie_vdrop_hack", SHAck, 0);
    drain();
    tick();
    M_ACK_I = 1'b0;
    idle_expect("tie_dead");
    drain();
    tick();
    push("tie_hgnt", SGnt, 2);
    push("tie_hmcyc", SMCyc, 1);
    drain();

    // Host write passes address, data, byte selects and WE
    tick();
    H_ADR_I = 13'h1ABC; H_DAT_I = 16'hBEEF; H_SEL_I = 2'b10; H_WE_I = 1'b1; M_ACK_I = 1'b1;
    push("wr_madr", SMAdr, 13'h1ABC);
    push("wr_mdat", SMDat, 16'hBEEF);
    push("wr_mwe", SMWe, 1);
    push("wr_msel", SMSel, 2'b10);
    push("wr_hack", SHAck, 1);
    push("wr_vack", SVAck, 0);
    drain();
    tick();
    M_ACK_I = 1'b0;
    push("wr_hack0", SHAck, 0);
    push("wr_gnt", SGnt, 2);
    drain();
    // STB low with CYC held keeps the grant
    tick();
    H_STB_I = 1'b0;
    push("stb0_gnt", SGnt, 2);
    push("stb0_mcyc", SMCyc, 1);
    push("stb0_mstb", SMStb, 0);
    drain();
    tick();
    H_CYC_I = 1'b0; H_WE_I = 1'b0;
    push("hdrop_gnt", SGnt, 2);
    push("hdrop_mcyc", SMCyc, 0);
    drain();
    tick();
    H_WE_I = 1'b1;
    idle_expect("hidle");
    push("hidle_madr", SMAdr, 0);
    push("hidle_mdat", SMDat, 0);
    push("hidle_msel", SMSel, 0);
    push("hidle_mwe", SMWe, 0);
    drain();

    // 8-beat host burst with video knocking throughout: no preemption
    tick();
    H_WE_I = 1'b0; H_CYC_I = 1'b1; H_STB_I = 1'b1;
    idle_expect("burst_req");
    drain();
    for (int i = 0; i < 8; i++) begin
      tick();
      V_CYC_I = 1'b1; V_STB_I = 1'b1; M_ACK_I = 1'b1; M_DAT_I = 16'(16'hA000 + i);
      push($sformatf("burst%0d_gnt", i), SGnt, 2);
      push($sformatf("burst%0d_hack", i), SHAck, 1);
      push($sformatf("burst%0d_vack", i), SVAck, 0);
      push($sformatf("burst%0d_hdat", i), SHDat, 16'(16'hA000 + i));
      drain();
    end
    tick();
    H_CYC_I = 1'b0; H_STB_I = 1'b0; M_ACK_I = 1'b0;
    push("burst_end_gnt", SGnt, 2);
    drain();
    tick();
    push("burst_dead_gnt", SGnt, 0);
    push("burst_dead_mcyc", SMCyc, 0);
    drain();
    tick();
    push("burst_vgnt", SGnt, 1);
    push("burst_vmcyc", SMCyc, 1);
    drain();

    // Video read ignores a stray host WE
    tick();
    H_WE_I = 1'b1; V_ADR_I = 13'h0456; M_ACK_I = 1'b1; M_DAT_I = 16'h5A5A;
    push("vrd_mwe", SMWe, 0);
    push("vrd_msel", SMSel, 2'b11);
    push("vrd_madr", SMAdr, 13'h0456);
    push("vrd_mdat", SMDat, 0);
    push("vrd_vack", SVAck, 1);
    push("vrd_vdat", SVDat, 16'h5A5A);
    drain();

    // Reset mid-tenure aborts the grant, then arbitration restarts
    tick();
    RST_I = 1'b0;
    push("rstmid_pre_gnt", SGnt, 1);
    drain();
    tick();
    RST_I = 1'b1;
    idle_expect("rstmid");
    drain();
    tick();
    push("rstmid_regnt", SGnt, 1);
    push("rstmid_revack", SVAck, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL provide parameter ADR_W, default 13, meaning the VRAM word-address width.
REQ-002 SHALL provide parameter DAT_W, default 16, meaning the VRAM data width.
REQ-003 SHALL provide CLK_I  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide RST_I  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide V_ADR_I  input  ADR_W  video-fetch read address.
REQ-006 SHALL provide V_CYC_I, V_STB_I  input  1 each  video-fetch Wishbone cycle and strobe.
REQ-007 SHALL provide V_ACK_O  output  1  video-fetch acknowledge.
REQ-008 SHALL provide V_DAT_O  output  DAT_W  video-fetch read data.
REQ-009 SHALL provide H_ADR_I  input  ADR_W  host address.
REQ-010 SHALL provide H_CYC_I, H_STB_I, H_WE_I  input  1 each  host cycle, strobe and write enable.
REQ-011 SHALL provide H_SEL_I  input  2  host byte selects.
REQ-012 SHALL provide H_DAT_I  input  DAT_W  host write data.
REQ-013 SHALL provide H_DAT_O  output  DAT_W  host read data.
REQ-014 SHALL provide H_ACK_O  output  1  host acknowledge.
REQ-015 SHALL provide M_ADR_O, M_DAT_O  output  ADR_W, DAT_W  VRAM address and write data.
REQ-016 SHALL provide M_CYC_O, M_STB_O, M_WE_O  output  1 each  VRAM cycle, strobe and write enable.
REQ-017 SHALL provide M_SEL_O  output  2  VRAM byte selects.
REQ-018 SHALL provide M_DAT_I  input  DAT_W  VRAM read data.
REQ-019 SHALL provide M_ACK_I  input  1  VRAM acknowledge.
REQ-020 SHALL provide GNT_O  output  2  grant state: 00 idle, 01 video, 10 host.

Function
REQ-021 SHALL implement a registered grant FSM with states IDLE, VIDEO and HOST.
REQ-022 IDLE SHALL go to VIDEO if V_CYC_I=1, otherwise to HOST if H_CYC_I=1, otherwise stay in IDLE; video has strict priority when both request in the same cycle.
REQ-023 VIDEO SHALL stay in VIDEO while V_CYC_I=1 and SHALL go to IDLE on the first cycle V_CYC_I=0.
REQ-024 HOST SHALL stay in HOST while H_CYC_I=1 and SHALL go to IDLE on the first cycle H_CYC_I=0.
REQ-025 The bus SHALL be locked for the whole CYC tenure; there SHALL be no preemption mid-cycle, including when video requests during a host burst.
REQ-026 Every grant change SHALL pass through IDLE, which costs exactly one dead cycle between tenures.
REQ-027 Grant latency: a request arriving in IDLE at edge n SHALL see its M_CYC_O/M_STB_O asserted in the cycle following edge n+1.
REQ-028 In IDLE, M_CYC_O, M_STB_O, M_WE_O, V_ACK_O and H_ACK_O SHALL all be 0, and M_SEL_O, M_ADR_O and M_DAT_O SHALL be 0.
REQ-029 In VIDEO, the outputs SHALL be driven combinationally as M_ADR_O=V_ADR_I, M_CYC_O=V_CYC_I, M_STB_O=V_STB_I, M_WE_O=0, M_SEL_O=11, M_DAT_O=0.
REQ-030 In HOST, the outputs SHALL be driven combinationally as M_ADR_O=H_ADR_I, M_CYC_O=H_CYC_I, M_STB_O=H_STB_I, M_WE_O=H_WE_I, M_SEL_O=H_SEL_I, M_DAT_O=H_DAT_I.
REQ-031 V_ACK_O SHALL equal M_ACK_I only in VIDEO, and H_ACK_O SHALL equal M_ACK_I only in HOST; the non-granted ACK SHALL be 0.
REQ-032 V_DAT_O and H_DAT_O SHALL both carry M_DAT_I unconditionally.
REQ-033 An M_ACK_I arriving in IDLE SHALL be discarded.
REQ-034 STB deasserted while CYC is held SHALL keep the grant and SHALL pass STB=0 to VRAM.
REQ-035 GNT_O SHALL reflect the registered state.

Reset
REQ-036 While RST_I=0 at a clock edge, the FSM SHALL enter IDLE, so all M_* control outputs, both ACKs and GNT_O are 0 on the following cycle, regardless of any pending requests.
REQ-037 Reset asserted mid-tenure SHALL abort the grant immediately, with no ACK forwarded; after release, arbitration SHALL restart from IDLE per REQ-022.

Verification
REQ-038 The bench SHALL cover: V_CYC/H_CYC both rising in the same IDLE cycle -> GNT_O=01 next cycle, H_ACK_O stays 0 until V_CYC drops, then one IDLE cycle, then GNT_O=10.
REQ-039 The bench SHALL cover: host write at H_ADR_I=0x1ABC, H_DAT_I=0xBEEF, SEL=10 -> M_ADR_O=0x1ABC, M_DAT_O=0xBEEF, M_WE_O=1, M_SEL_O=10 during HOST; H_ACK_O mirrors M_ACK_I.
REQ-040 The bench SHALL cover: video requests during an 8-beat host burst -> no preemption, GNT_O stays 10 for all 8 ACKs, and VIDEO is granted 2 cycles after H_CYC_I falls.
REQ-041 The bench SHALL cover: video read with H_WE_I=1 held on the idle host port -> M_WE_O=0, M_SEL_O=11, and V_DAT_O=M_DAT_I=0x5A5A on ACK.
REQ-042 The bench SHALL cover: RST_I=0 pulsed during VIDEO with M_ACK_I=1 -> next cycle GNT_O=00, V_ACK_O=0, M_CYC_O=0.
REQ-043 The bench SHALL cover: spurious M_ACK_I=1 in IDLE -> both ACK outputs 0 and state unchanged.
